bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumer end of the game core's bcd_tens/bcd_units result interface.
- Captures a two-digit BCD value on a load strobe and time-multiplexes it onto a shared 7-segment bus with two digit enables.
- Supports leading-zero blanking, blink and invalid-digit flagging.
- Sits between the game core and the board's 2-digit display.

Parameters:
REFRESH_DIV, 4, clock cycles each digit slot is driven (>=2)
BLINK_DIV, 8, scan frames per blink half-period (>=1); one frame = 2*REFRESH_DIV cycles

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
bcd_tens  input  4  tens digit from game core
bcd_units  input  4  units digit from game core
load  input  1  capture strobe; sampled every rising edge
blank_lz  input  1  1 = blank tens digit when held tens == 0
blink  input  1  1 = blink whole display
seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high (1 = lit)
digit_en  output  2  one-hot digit enable; [0] = units, [1] = tens
err  output  1  1 = currently held value has a digit > 9
loaded  output  1  one-cycle acknowledge of a capture

Behaviour:
- Reset (rst = 0, async, effective immediately):
  - held digits = 0; seg = 0; digit_en = 00; err = 0; loaded = 0.
  - Scan counter = 0; frame counter = 0; blink phase = visible; FSM = IDLE.
- FSM states: IDLE, SCAN_U, SCAN_T.
  - IDLE: digit_en = 00, seg = 0. Stays here until the first load after reset.
  - Load sampled in IDLE: FSM -> SCAN_U, cnt = 0.
  - SCAN_U/SCAN_T: cnt counts 0..REFRESH_DIV-1. At cnt == REFRESH_DIV-1, FSM toggles to the other state and cnt -> 0.
  - Each slot lasts exactly REFRESH_DIV cycles.
  - Leaving SCAN_T increments the frame counter.
- Load:
  - At an edge with load = 1, held digits <= inputs and err <= (tens > 9) | (units > 9).
  - loaded = 1 for exactly the next cycle; load held high for k cycles gives k loaded cycles.
  - In SCAN_*, load does not disturb cnt or state; scan timing is continuous.
- Output register:
  - seg and digit_en are registered together from current state and held digits, one cycle behind the state.
  - They never mismatch: one digit's pattern is never shown on the other anode.
  - First digit_en = 01 appears at the edge after the capturing edge.
- Decode:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Any digit 10-15 decodes to "E" = 79 (hex).
- Leading-zero blanking: blank_lz = 1 and held tens == 0 -> SCAN_T slot drives digit_en = 00, seg = 0. Slot time is still consumed. Units are never blanked.
- Blink:
  - blink = 1: phase toggles each time the frame counter reaches BLINK_DIV; the frame counter then clears.
  - Dark phase forces digit_en = 00, seg = 0.
  - blink = 0: phase held visible, frame counter held 0. Blinking restarts visible.
- Simultaneous events: load on the same edge as a slot switch -> the new digit shows in the new slot. Inputs are sampled, not latched, so blank_lz/blink changes take effect on the next edge.
- Reset mid-scan: outputs clear asynchronously; after release the block returns to IDLE and shows nothing until the next load.

Test Plan:
- REFRESH_DIV = 4, BLINK_DIV = 2 throughout.
- 1. Reset released, no load for 20 cycles -> digit_en = 00, seg = 00, err = 0, loaded = 0 throughout.
- 2. Load tens = 3, units = 7, blank_lz = 0 -> loaded high exactly 1 cycle. Then repeating pattern: digit_en = 01 / seg = 07 for 4 cycles, then digit_en = 10 / seg = 4F for 4 cycles.
- 3. Load 0,5 with blank_lz = 1 -> units slot 01 / 6D, tens slot 00 / 00. Set blank_lz = 0 -> tens slot 10 / 3F from the next edge.
- 4. Load tens = C, units = 2 -> err = 1, tens slot seg = 79, units slot seg = 5B. Load 1,2 -> err = 0, tens seg = 06. Load during SCAN_U mid-slot -> slot length stays 4 cycles.
- 5. Value 4,2 displayed, blink = 1 -> 16 cycles visible, 16 cycles dark (digit_en = 00), repeating. Drop blink during dark -> visible again within 2 cycles.
- 6. rst low mid-SCAN_T -> seg = 00, digit_en = 00 immediately without a clock edge. After release -> stays IDLE until load; first load resumes at SCAN_U.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// Two-digit BCD capture register plus a time-multiplexed 7-segment driver.
// Handles leading-zero blanking, whole-display blink and invalid-digit flagging.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_DIV   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_units,
    input  logic       load,
    input  logic       blank_lz,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic       err,
    output logic       loaded
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN_U = 2'd1,
        SCAN_T = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [FW-1:0] frame_cnt;
    logic          dark;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;

    logic slot_end;
    assign slot_end = (cnt == CNT_LAST);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h79;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
            dark      <= 1'b0;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            err       <= 1'b0;
            loaded    <= 1'b0;
            seg       <= 7'h00;
            digit_en  <= 2'b00;
        end else begin
            loaded <= load;
            if (load) begin
                tens_q  <= bcd_tens;
                units_q <= bcd_units;
                err     <= (bcd_tens > 4'd9) | (bcd_units > 4'd9);
            end

            // Scan timing runs freely once started; later loads only replace the digits.
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (load) state <= SCAN_U;
                end
                SCAN_U, SCAN_T: begin
                    if (slot_end) begin
                        cnt   <= '0;
                        state <= (state == SCAN_U) ? SCAN_T : SCAN_U;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase

            // A frame completes when the tens slot is left.
            if (!blink) begin
                frame_cnt <= '0;
                dark      <= 1'b0;
            end else if (state == SCAN_T && slot_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    dark      <= ~dark;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end

            // Pattern and anode come from the same state sample so they never disagree.
            seg      <= 7'h00;
            digit_en <= 2'b00;
            if (!dark) begin
                if (state == SCAN_U) begin
                    seg      <= decode(units_q);
                    digit_en <= 2'b01;
                end else if (state == SCAN_T && !(blank_lz && tens_q == 4'd0)) begin
                    seg      <= decode(tens_q);
                    digit_en <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner: table of load vectors checked over a full
// scan frame, plus hand sequences for blanking change, blink, held load and reset.
module tb_bcd_display_scanner;

    localparam int RD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       load;
    logic       blank_lz;
    logic       blink;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic       err;
    logic       loaded;

    int total = 0;
    int bad   = 0;
    int k     = 0;   // edges since the capture that started scanning

    bcd_display_scanner #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .bcd_tens(bcd_tens), .bcd_units(bcd_units),
        .load(load), .blank_lz(blank_lz), .blink(blink),
        .seg(seg), .digit_en(digit_en), .err(err), .loaded(loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tens;
        logic [3:0] units;
        logic       blz;
        logic [6:0] seg_u;
        logic [6:0] seg_t;
        logic [1:0] en_t;
        logic       err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Output at sample k shows the slot the FSM was in after edge k-1.
    function automatic int slot(input int kk);
        return ((kk - 1) / RD) % 2;
    endfunction

    task automatic check_disp(input logic [6:0] su, input logic [6:0] st,
                              input logic [1:0] et, input logic dk);
        if (dk) begin
            check("dark_en", digit_en, 2'b00);
            check("dark_seg", seg, 7'h00);
        end else if (slot(k) == 0) begin
            check("units_en", digit_en, 2'b01);
            check("units_seg", seg, su);
        end else begin
            check("tens_en", digit_en, et);
            check("tens_seg", seg, st);
        end
    endtask

    task automatic check_idle();
        check("idle_en", digit_en, 2'b00);
        check("idle_seg", seg, 7'h00);
        check("idle_err", err, 1'b0);
        check("idle_loaded", loaded, 1'b0);
    endtask

    initial begin
        vecs[0] = '{4'd3,  4'd7,  1'b0, 7'h07, 7'h4F, 2'b10, 1'b0};
        vecs[1] = '{4'd0,  4'd5,  1'b1, 7'h6D, 7'h00, 2'b00, 1'b0};
        vecs[2] = '{4'd0,  4'd5,  1'b0, 7'h6D, 7'h3F, 2'b10, 1'b0};
        vecs[3] = '{4'hC,  4'd2,  1'b0, 7'h5B, 7'h79, 2'b10, 1'b1};
        vecs[4] = '{4'd1,  4'd2,  1'b1, 7'h5B, 7'h06, 2'b10, 1'b0};
        vecs[5] = '{4'd9,  4'd8,  1'b0, 7'h7F, 7'h6F, 2'b10, 1'b0};
        vecs[6] = '{4'd6,  4'd4,  1'b0, 7'h66, 7'h7D, 2'b10, 1'b0};
        vecs[7] = '{4'd0,  4'hF,  1'b1, 7'h79, 7'h00, 2'b00, 1'b1};
        vecs[8] = '{4'hA,  4'd0,  1'b1, 7'h3F, 7'h79, 2'b10, 1'b1};

        rst = 1'b0; load = 1'b0; bcd_tens = 4'd0; bcd_units = 4'd0;
        blank_lz = 1'b0; blink = 1'b0;

        // Reset state, then idle with no load.
        #12;
        check_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_idle();
        end

        // Table: each load checked over a full frame; loads land at arbitrary slot phase.
        for (int i = 0; i < 9; i++) begin
            bcd_tens  = vecs[i].tens;
            bcd_units = vecs[i].units;
            blank_lz  = vecs[i].blz;
            load      = 1'b1;
            if (i == 0) begin
                @(posedge clk);
                #1;
                k = 0;
                check("first_capture_en", digit_en, 2'b00);
            end else begin
                cyc();
            end
            check("loaded_pulse", loaded, 1'b1);
            check("err_flag", err, vecs[i].err);
            load = 1'b0;
            for (int c = 0; c < 2 * RD; c++) begin
                cyc();
                if (c == 0) check("loaded_drop", loaded, 1'b0);
                check_disp(vecs[i].seg_u, vecs[i].seg_t, vecs[i].en_t, 1'b0);
            end
            // Extra idle-ish cycles shift the next load's slot phase.
            for (int c = 0; c < i % 3; c++) cyc();
        end

        // Load held high for three cycles gives three loaded cycles.
        bcd_tens = 4'd3; bcd_units = 4'd7; blank_lz = 1'b0; load = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("held_load", loaded, 1'b1);
        end
        load = 1'b0;
        cyc();
        check("held_load_end", loaded, 1'b0);
        for (int c = 0; c < 2 * RD; c++) begin
            cyc();
            check_disp(7'h07, 7'h4F, 2'b10, 1'b0);
        end

        // Blanking released inside a tens slot takes effect on the next sample.
        bcd_tens = 4'd0; bcd_units = 4'd5; blank_lz = 1'b1; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        for (int c = 0; c < 2 * RD && !(slot(k) == 1 && slot(k + 1) == 1); c++) begin
            check_disp(7'h6D, 7'h00, 2'b00, 1'b0);
            cyc();
        end
        check("blank_on_en", digit_en, 2'b00);
        check("blank_on_seg", seg, 7'h00);
        blank_lz = 1'b0;
        cyc();
        check("blank_off_en", digit_en, 2'b10);
        check("blank_off_seg", seg, 7'h3F);

        // Blink, started at a frame boundary: 16 visible, 16 dark, repeating.
        bcd_tens = 4'd4; bcd_units = 4'd2; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int c = 0; c < 2 * RD && (k % (2 * RD)) != 0; c++) cyc();
        begin
            int b0;
            b0 = k;
            blink = 1'b1;
            for (int j = 0; j <= 52; j++) begin
                cyc();
                check_disp(7'h5B, 7'h66, 2'b10, ((k - b0 - 1) / (2 * RD * BD)) % 2 == 1);
            end
            blink = 1'b0;
            cyc();
            for (int j = 0; j < 10; j++) begin
                cyc();
                check_disp(7'h5B, 7'h66, 2'b10, 1'b0);
            end
        end

        // Asynchronous reset in the middle of a tens slot.
        bcd_tens = 4'hB; bcd_units = 4'd1; load = 1'b1;
        cyc();
        check("err_before_reset", err, 1'b1);
        load = 1'b0;
        for (int c = 0; c < 4 * RD && !(slot(k) == 1 && ((k - 1) % RD) == 1); c++) cyc();
        check("pre_reset_en", digit_en, 2'b10);
        rst = 1'b0;
        #2;
        check("async_rst_en", digit_en, 2'b00);
        check("async_rst_seg", seg, 7'h00);
        check("async_rst_err", err, 1'b0);
        check("async_rst_loaded", loaded, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            check_idle();
        end
        bcd_tens = 4'd2; bcd_units = 4'd1; load = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        load = 1'b0;
        check("restart_loaded", loaded, 1'b1);
        for (int c = 0; c < 4 * RD; c++) begin
            cyc();
            check_disp(7'h06, 7'h5B, 2'b10, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
